// File: rtl/imem_if.sv
// imem_if: fetch request/response bus between the core (master) and instruction memory (slave).
interface imem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: instruction memory answering one fetch at a time after LATENCY wait cycles.
// Define IMEM_MISALIGN_CHECK_EN to fault in-range fetches whose address is not word aligned.
module imem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int          LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    imem_if.slave                    bus,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] mem [DEPTH];
    logic [31:0] offset;
    logic        in_range, bad, accept;
    assign offset   = bus.req_addr - BASE_ADDR;
    assign in_range = offset < 32'(DEPTH) * 32'd4;
`ifdef IMEM_MISALIGN_CHECK_EN
    assign bad = !in_range || (bus.req_addr[1:0] != 2'b00);
`else
    assign bad = !in_range;
`endif
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    // Preload port has no reset so images can be written while rst_n is held low.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = LATENCY > 0 ? WAIT : RESP;
                cnt_d   = LAT_M1;
                data_d  = bad ? 32'd0 : mem[offset[AW+1:2]];
                err_d   = bad;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
            end
            RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
endmodule
